apb_slave_decoder: RTL and testbench
====================================

Name: apb_slave_decoder

Overview:
- Sits directly downstream of the team's N-to-1 APB master mux.
- Takes the single arbitrated APB transfer and routes it to one of NUM_SLAVES APB slaves by address region.
- Returns the selected slave's response upstream.
- Contains a built-in error responder for unmapped addresses, a per-transfer FSM, and registered status pulses for the interrupt/status block.

Parameters:
- NUM_SLAVES, 4, number of downstream slaves (2..16).
- APB_ADDR_WIDTH, 32, address width.
- APB_DATA_WIDTH, 32, data width.
- APB_STRB_WIDTH, 4, byte-strobe width (APB_DATA_WIDTH/8).
- REGION_BITS, 12, log2 of per-slave region size (4 KiB).
- BASE_ADDR, 32'h4000_0000, base of the slave window; must be aligned to 2^(REGION_BITS+IDX_W).
- TIMEOUT_CYCLES, 256, ACCESS-cycle limit; only used when APB_DEC_TIMEOUT_EN is defined.

Ports:
- PCLK  in  1  clock.
- PRESETn  in  1  asynchronous, active-low reset.
- PSEL_up  in  1  select from mux.
- PENABLE_up  in  1  enable from mux.
- PADDR_up  in  APB_ADDR_WIDTH  address.
- PWRITE_up  in  1  write flag.
- PWDATA_up  in  APB_DATA_WIDTH  write data.
- PSTRB_up  in  APB_STRB_WIDTH  byte strobes.
- PPROT_up  in  3  protection.
- PRDATA_up  out  APB_DATA_WIDTH  read data to mux.
- PREADY_up  out  1  ready to mux.
- PSLVERR_up  out  1  error to mux.
- PSEL_dn  out  [NUM_SLAVES] x 1  per-slave select.
- PENABLE_dn, PADDR_dn, PWRITE_dn, PWDATA_dn, PSTRB_dn, PPROT_dn  out  as upstream  broadcast to all slaves.
- PRDATA_dn  in  [NUM_SLAVES] x APB_DATA_WIDTH  slave read data.
- PREADY_dn  in  [NUM_SLAVES] x 1  slave ready.
- PSLVERR_dn  in  [NUM_SLAVES] x 1  slave error.
- unmapped_pulse  out  1  one-cycle pulse: unmapped transfer completed.
- prot_err_pulse  out  1  one-cycle pulse: upstream protocol violation.

Behaviour:
- Clock PCLK; reset PRESETn, asynchronous, active-low. Reset values: state IDLE, idx_q 0, mapped_q 0, all pulses 0. With PSEL_up=0 every output is 0.
- IDX_W = $clog2(NUM_SLAVES).
- Decode:
  - hit = PADDR_up[APB_ADDR_WIDTH-1:REGION_BITS+IDX_W] equals the same bits of BASE_ADDR.
  - idx = PADDR_up[REGION_BITS +: IDX_W].
  - mapped = hit && idx < NUM_SLAVES.
- FSM states: IDLE, ACCESS.
- IDLE:
  - A setup cycle (PSEL_up=1, PENABLE_up=0) registers idx_q/mapped_q and moves to ACCESS.
  - PSEL_dn[idx] = PSEL_up & mapped, combinational, so the slave sees its setup cycle with zero added latency.
  - PREADY_up = 0.
  - PSEL_up=1 with PENABLE_up=1 in IDLE is a violation: pulse prot_err_pulse, stay IDLE, no slave selected.
- ACCESS:
  - PSEL_dn[idx_q] = PSEL_up & mapped_q.
  - PENABLE_dn = PENABLE_up.
  - Mapped transfer: PRDATA_up/PREADY_up/PSLVERR_up = PRDATA_dn/PREADY_dn/PSLVERR_dn[idx_q]; return to IDLE on that PREADY.
  - Unmapped transfer: the error responder drives PREADY_up=1, PSLVERR_up=1, PRDATA_up=0 in the first ACCESS cycle; return to IDLE and pulse unmapped_pulse (registered, the cycle after completion).
  - PSEL_up dropping in ACCESS without completion: abort to IDLE, deassert all PSEL_dn, pulse prot_err_pulse.
- PENABLE_dn = 0 in IDLE.
- PADDR/PWRITE/PWDATA/PSTRB/PPROT are passed through unregistered at all times.
- Back-to-back transfers: the setup cycle immediately after a completion is accepted, because the FSM is already in IDLE.
- Address change during ACCESS is ignored for routing; idx_q holds.
- Upstream response outputs are 0 outside the ACCESS completion path.
- Reset asserted mid-transfer: immediate return to IDLE, all PSEL_dn=0.

Optional Feature:
- Macro: APB_DEC_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES)+1 clears on entry to ACCESS and increments each ACCESS cycle without slave PREADY.
  - When the count reaches TIMEOUT_CYCLES-1, the decoder forces PREADY_up=1, PSLVERR_up=1, PRDATA_up=0 and deasserts PSEL_dn/PENABLE_dn in that cycle.
  - It then returns to IDLE and pulses timeout_pulse (extra output port, 1 bit).
- Not defined: no counter and no timeout_pulse port; a stalled slave stalls the bus indefinitely.

Test Plan:
- Write 0x4000_1004 data 0xDEAD_BEEF, slave 1 ready in the first ACCESS cycle -> only PSEL_dn[1] asserted for 2 cycles, PENABLE_dn in cycle 2, PREADY_up=1, PSLVERR_up=0.
- Read 0x4000_3000, slave 3 returns 0x1234_5678 after 3 wait states -> PRDATA_up=0x1234_5678 only in the PREADY cycle; transfer lasts 5 cycles.
- Read 0x5000_0000 (hit fails) -> no PSEL_dn; PREADY_up=1, PSLVERR_up=1, PRDATA_up=0 in cycle 2; unmapped_pulse in cycle 3.
- Back-to-back write to slave 0 then read from slave 2 with no idle cycle -> correct select per transfer; 4 cycles total.
- PSEL_up dropped mid-ACCESS, and PENABLE_up=1 without a setup cycle -> each gives prot_err_pulse=1 for one cycle with FSM in IDLE.
- APB_DEC_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, slave 2 never ready -> PREADY_up=PSLVERR_up=1 in ACCESS cycle 16; timeout_pulse next cycle; the following transfer to slave 0 completes normally.

Source files
------------

// File: rtl/apb_slave_decoder_if.sv
// ---------------------------------------------------------------------------
// apb_slave_decoder_if
//
// Purpose: the upstream APB bus that links the N-to-1 master mux to the
// slave decoder. It carries one arbitrated transfer and its response.
//
// Parameters:
//   ADDR_W  address width
//   DATA_W  data width
//   STRB_W  byte-strobe width (DATA_W/8)
//
// Signals:
//   PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT   request (mux -> decoder)
//   PRDATA, PREADY, PSLVERR                              response (decoder -> mux)
//
// Modports:
//   master  the mux side (drives the request, receives the response)
//   slave   the decoder side (receives the request, drives the response)
// ---------------------------------------------------------------------------
interface apb_slave_decoder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int STRB_W = 4
);
    logic              PSEL;
    logic              PENABLE;
    logic [ADDR_W-1:0] PADDR;
    logic              PWRITE;
    logic [DATA_W-1:0] PWDATA;
    logic [STRB_W-1:0] PSTRB;
    logic [2:0]        PPROT;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_slave_decoder.sv
// ---------------------------------------------------------------------------
// apb_slave_decoder
//
// Purpose: routes the single arbitrated APB transfer coming out of the master
// mux to one of NUM_SLAVES slaves, selected by 2^REGION_BITS-byte region
// inside the window starting at BASE_ADDR, and returns that slave's response
// upstream. Addresses outside the window (or beyond the last slave) are
// answered by a built-in error responder. Registered one-cycle status pulses
// report unmapped transfers and upstream protocol violations.
//
// Optional feature (macro APB_DEC_TIMEOUT_EN): an ACCESS-phase watchdog that
// terminates a transfer with PSLVERR after TIMEOUT_CYCLES cycles without
// slave PREADY and adds the timeout_pulse output. Without the macro a stalled
// slave stalls the bus indefinitely.
//
// Ports:
//   PCLK, PRESETn          clock, asynchronous active-low reset
//   up                     upstream APB bus (slave modport)
//   PSEL_dn[NUM_SLAVES]    per-slave select
//   PENABLE_dn, PADDR_dn, PWRITE_dn, PWDATA_dn, PSTRB_dn, PPROT_dn
//                          request broadcast to every slave
//   PRDATA_dn, PREADY_dn, PSLVERR_dn
//                          per-slave responses
//   unmapped_pulse         unmapped transfer completed (cycle after)
//   prot_err_pulse         upstream protocol violation (cycle after)
//   timeout_pulse          watchdog fired (only with APB_DEC_TIMEOUT_EN)
// ---------------------------------------------------------------------------
module apb_slave_decoder #(
    parameter int                        NUM_SLAVES     = 4,
    parameter int                        APB_ADDR_WIDTH = 32,
    parameter int                        APB_DATA_WIDTH = 32,
    parameter int                        APB_STRB_WIDTH = 4,
    parameter int                        REGION_BITS    = 12,
    parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h4000_0000,
    parameter int                        TIMEOUT_CYCLES = 256
) (
    input  logic                                           PCLK,
    input  logic                                           PRESETn,
    apb_slave_decoder_if.slave                             up,
    output logic [NUM_SLAVES-1:0]                          PSEL_dn,
    output logic                                           PENABLE_dn,
    output logic [APB_ADDR_WIDTH-1:0]                      PADDR_dn,
    output logic                                           PWRITE_dn,
    output logic [APB_DATA_WIDTH-1:0]                      PWDATA_dn,
    output logic [APB_STRB_WIDTH-1:0]                      PSTRB_dn,
    output logic [2:0]                                     PPROT_dn,
    input  logic [NUM_SLAVES-1:0][APB_DATA_WIDTH-1:0]      PRDATA_dn,
    input  logic [NUM_SLAVES-1:0]                          PREADY_dn,
    input  logic [NUM_SLAVES-1:0]                          PSLVERR_dn,
    output logic                                           unmapped_pulse,
    output logic                                           prot_err_pulse
`ifdef APB_DEC_TIMEOUT_EN
    ,
    output logic                                           timeout_pulse
`endif
);

    localparam int IDX_W = $clog2(NUM_SLAVES);
    localparam int HIT_LSB = REGION_BITS + IDX_W;
    localparam logic [IDX_W:0] NUM_SLAVES_W = NUM_SLAVES[IDX_W:0];

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    // Elaboration-time guards on the parameter set
    if (NUM_SLAVES < 2 || NUM_SLAVES > 16) begin : g_chk_num_slaves
        $error("apb_slave_decoder: NUM_SLAVES must be in 2..16");
    end
    if (APB_STRB_WIDTH * 8 != APB_DATA_WIDTH) begin : g_chk_strb
        $error("apb_slave_decoder: APB_STRB_WIDTH must equal APB_DATA_WIDTH/8");
    end
    if (BASE_ADDR[HIT_LSB-1:0] != '0) begin : g_chk_base
        $error("apb_slave_decoder: BASE_ADDR not aligned to the slave window");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_chk_timeout
        $error("apb_slave_decoder: TIMEOUT_CYCLES must be at least 2");
    end

`ifdef APB_DEC_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_pulse_q, timeout_pulse_d;
`endif

    logic [0:0]                state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      mapped_q, mapped_d;
    logic                      unmapped_pulse_q, unmapped_pulse_d;
    logic                      prot_err_pulse_q, prot_err_pulse_d;

    logic                      dec_hit;
    logic [IDX_W-1:0]          dec_idx;
    logic                      dec_mapped;

    logic [NUM_SLAVES-1:0]     psel_dn;
    logic                      penable_dn;
    logic [APB_DATA_WIDTH-1:0] prdata_up;
    logic                      pready_up;
    logic                      pslverr_up;

    // Address decode of the live upstream address; only consumed in the
    // setup cycle, after which idx_q/mapped_q own the routing.
    assign dec_hit    = (up.PADDR[APB_ADDR_WIDTH-1:HIT_LSB] == BASE_ADDR[APB_ADDR_WIDTH-1:HIT_LSB]);
    assign dec_idx    = up.PADDR[REGION_BITS +: IDX_W];
    assign dec_mapped = dec_hit && ({1'b0, dec_idx} < NUM_SLAVES_W);

    // Transfer FSM and response mux. The select in IDLE is purely
    // combinational so the target slave sees its setup cycle with no added
    // latency; in ACCESS the latched index steers select and response.
    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        mapped_d         = mapped_q;
        unmapped_pulse_d = 1'b0;
        prot_err_pulse_d = 1'b0;
        psel_dn          = '0;
        penable_dn       = 1'b0;
        prdata_up        = '0;
        pready_up        = 1'b0;
        pslverr_up       = 1'b0;
`ifdef APB_DEC_TIMEOUT_EN
        cnt_d            = cnt_q;
        timeout_pulse_d  = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (up.PSEL && !up.PENABLE) begin
                    if (dec_mapped) begin
                        psel_dn[dec_idx] = 1'b1;
                    end
                    idx_d    = dec_idx;
                    mapped_d = dec_mapped;
                    state_d  = ST_ACCESS;
`ifdef APB_DEC_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end else if (up.PSEL && up.PENABLE) begin
                    // Access phase without a preceding setup phase
                    prot_err_pulse_d = 1'b1;
                end
            end

            ST_ACCESS: begin
                if (!up.PSEL) begin
                    // Master abandoned the transfer before completion
                    state_d          = ST_IDLE;
                    prot_err_pulse_d = 1'b1;
                end else if (!mapped_q) begin
                    // Error responder: complete immediately with PSLVERR
                    penable_dn       = up.PENABLE;
                    pready_up        = 1'b1;
                    pslverr_up       = 1'b1;
                    state_d          = ST_IDLE;
                    unmapped_pulse_d = 1'b1;
                end else begin
                    psel_dn[idx_q] = 1'b1;
                    penable_dn     = up.PENABLE;
                    prdata_up      = PRDATA_dn[idx_q];
                    pready_up      = PREADY_dn[idx_q];
                    pslverr_up     = PSLVERR_dn[idx_q];
                    if (PREADY_dn[idx_q]) begin
                        state_d = ST_IDLE;
                    end
`ifdef APB_DEC_TIMEOUT_EN
                    else if (cnt_q == TIMEOUT_LAST) begin
                        // Watchdog: withdraw the slave and answer with an error
                        psel_dn         = '0;
                        penable_dn      = 1'b0;
                        prdata_up       = '0;
                        pready_up       = 1'b1;
                        pslverr_up      = 1'b1;
                        state_d         = ST_IDLE;
                        timeout_pulse_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, latched routing and status pulses
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q          <= ST_IDLE;
            idx_q            <= '0;
            mapped_q         <= 1'b0;
            unmapped_pulse_q <= 1'b0;
            prot_err_pulse_q <= 1'b0;
`ifdef APB_DEC_TIMEOUT_EN
            cnt_q            <= '0;
            timeout_pulse_q  <= 1'b0;
`endif
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            mapped_q         <= mapped_d;
            unmapped_pulse_q <= unmapped_pulse_d;
            prot_err_pulse_q <= prot_err_pulse_d;
`ifdef APB_DEC_TIMEOUT_EN
            cnt_q            <= cnt_d;
            timeout_pulse_q  <= timeout_pulse_d;
`endif
        end
    end

    assign PSEL_dn    = psel_dn;
    assign PENABLE_dn = penable_dn;
    assign PADDR_dn   = up.PADDR;
    assign PWRITE_dn  = up.PWRITE;
    assign PWDATA_dn  = up.PWDATA;
    assign PSTRB_dn   = up.PSTRB;
    assign PPROT_dn   = up.PPROT;

    assign up.PRDATA  = prdata_up;
    assign up.PREADY  = pready_up;
    assign up.PSLVERR = pslverr_up;

    assign unmapped_pulse = unmapped_pulse_q;
    assign prot_err_pulse = prot_err_pulse_q;
`ifdef APB_DEC_TIMEOUT_EN
    assign timeout_pulse  = timeout_pulse_q;
`endif

endmodule

// File: tb/tb_apb_slave_decoder.sv
// ---------------------------------------------------------------------------
// tb_apb_slave_decoder
//
// Purpose: self-checking bench for apb_slave_decoder (4 slaves, 4 KiB regions
// at 0x4000_0000). Directed scenarios plus a randomized transfer stream whose
// expectations come from a transaction-level model of the address map.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge. The timeout scenario is compiled in with APB_DEC_TIMEOUT_EN.
// ---------------------------------------------------------------------------
module tb_apb_slave_decoder;

    localparam int          NS   = 4;
    localparam int          AW   = 32;
    localparam int          DW   = 32;
    localparam int          SW   = 4;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic                   PCLK;
    logic                   PRESETn;
    logic [NS-1:0]          PSEL_dn;
    logic                   PENABLE_dn;
    logic [AW-1:0]          PADDR_dn;
    logic                   PWRITE_dn;
    logic [DW-1:0]          PWDATA_dn;
    logic [SW-1:0]          PSTRB_dn;
    logic [2:0]             PPROT_dn;
    logic [NS-1:0][DW-1:0]  PRDATA_dn;
    logic [NS-1:0]          PREADY_dn;
    logic [NS-1:0]          PSLVERR_dn;
    logic                   unmapped_pulse;
    logic                   prot_err_pulse;
`ifdef APB_DEC_TIMEOUT_EN
    logic                   timeout_pulse;
`endif

    int checks   = 0;
    int failures = 0;

    apb_slave_decoder_if #(.ADDR_W(AW), .DATA_W(DW), .STRB_W(SW)) up_if ();

    apb_slave_decoder #(
        .NUM_SLAVES     (NS),
        .APB_ADDR_WIDTH (AW),
        .APB_DATA_WIDTH (DW),
        .APB_STRB_WIDTH (SW),
        .REGION_BITS    (12),
        .BASE_ADDR      (BASE),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .PCLK           (PCLK),
        .PRESETn        (PRESETn),
        .up             (up_if),
        .PSEL_dn        (PSEL_dn),
        .PENABLE_dn     (PENABLE_dn),
        .PADDR_dn       (PADDR_dn),
        .PWRITE_dn      (PWRITE_dn),
        .PWDATA_dn      (PWDATA_dn),
        .PSTRB_dn       (PSTRB_dn),
        .PPROT_dn       (PPROT_dn),
        .PRDATA_dn      (PRDATA_dn),
        .PREADY_dn      (PREADY_dn),
        .PSLVERR_dn     (PSLVERR_dn),
        .unmapped_pulse (unmapped_pulse),
        .prot_err_pulse (prot_err_pulse)
`ifdef APB_DEC_TIMEOUT_EN
        ,
        .timeout_pulse  (timeout_pulse)
`endif
    );

    // Packed view of the control outputs:
    // {PSEL_dn[3:0], PENABLE_dn, PREADY_up, PSLVERR_up, unmapped_pulse, prot_err_pulse}
    logic [8:0] obs;
    assign obs = {PSEL_dn, PENABLE_dn, up_if.PREADY, up_if.PSLVERR, unmapped_pulse, prot_err_pulse};

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic drive_up(input logic sel, input logic en, input logic [31:0] addr,
                            input logic wr, input logic [31:0] wd);
        up_if.PSEL    = sel;
        up_if.PENABLE = en;
        up_if.PADDR   = addr;
        up_if.PWRITE  = wr;
        up_if.PWDATA  = wd;
        up_if.PSTRB   = 4'($urandom);
        up_if.PPROT   = 3'($urandom);
    endtask

    task automatic drive_dn(input logic [NS-1:0] rdy, input logic [NS-1:0] err);
        PREADY_dn  = rdy;
        PSLVERR_dn = err;
        for (int i = 0; i < NS; i++) PRDATA_dn[i] = $urandom;
    endtask

    task automatic half();
        @(negedge PCLK);
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic test_reset();
        logic [8:0] e;
        PRESETn = 1'b0;
        drive_up(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        drive_dn(4'b1111, 4'b1111);
        half();
        e = 9'b0000_0_0_0_0_0;
        checks++; if (obs !== e) begin failures++; $display("FAIL reset_ctl obs=%b exp=%b", obs, e); end
        checks++; if (up_if.PRDATA !== 32'h0) begin failures++; $display("FAIL reset_prdata got=%h exp=0", up_if.PRDATA); end
        tick();
        PRESETn = 1'b1;
        half();
        checks++; if (obs !== e) begin failures++; $display("FAIL post_reset_idle obs=%b exp=%b", obs, e); end
        tick();
    endtask

    task automatic test_write_single();
        logic [8:0] e;
        drive_up(1'b1, 1'b0, 32'h4000_1004, 1'b1, 32'hDEAD_BEEF);
        drive_dn(4'b0010, 4'b0000);
        half();
        e = 9'b0010_0_0_0_0_0;
        checks++; if (obs !== e) begin failures++; $display("FAIL wr_setup obs=%b exp=%b", obs, e); end
        checks++; if ({PADDR_dn, PWDATA_dn, PWRITE_dn} !== {32'h4000_1004, 32'hDEAD_BEEF, 1'b1})
            begin failures++; $display("FAIL wr_passthru addr=%h data=%h wr=%b", PADDR_dn, PWDATA_dn, PWRITE_dn); end
        tick();
        drive_up(1'b1, 1'b1, 32'h4000_1004, 1'b1, 32'hDEAD_BEEF);
        drive_dn(4'b0010, 4'b0000);
        half();
        e = 9'b0010_1_1_0_0_0;
        checks++; if (obs !== e) begin failures++; $display("FAIL wr_access obs=%b exp=%b", obs, e); end
        tick();
        drive_up(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        drive_dn(4'b0000, 4'b0000);
        half();
        e = 9'b0000_0_0_0_0_0;
        checks++; if (obs !== e) begin failures++; $display("FAIL wr_after obs=%b exp=%b", obs, e); end
        tick();
    endtask

    task automatic test_read_wait();
        logic [8:0] e;
        drive_up(1'b1, 1'b0, 32'h4000_3000, 1'b0, 32'h0);
        drive_dn(4'b0111, 4'b0000);
        PRDATA_dn[3] = 32'h0;
        half();
        e = 9'b1000_0_0_0_0_0;
        checks++; if (obs !== e) begin failures++; $display("FAIL rd_setup obs=%b exp=%b", obs, e); end
        tick();
        // Three wait states; the address wanders into slave 0's region mid-transfer
        for (int w = 0; w < 3; w++) begin
            drive_up(1'b1, 1'b1, (w == 1) ? 32'h4000_0000 : 32'h4000_3000, 1'b0, 32'h0);
            drive_dn(4'b0111, 4'b0111);
            PRDATA_dn[3] = 32'h0;
            half();
            e = 9'b1000_1_0_0_0_0;
            checks++; if (obs !== e) begin failures++; $display("FAIL rd_wait%0d obs=%b exp=%b", w, obs, e); end
            tick();
        end
        drive_up(1'b1, 1'b1, 32'h4000_3000, 1'b0, 32'h0);
        drive_dn(4'b1000, 4'b0000);
        PRDATA_dn[3] = 32'h1234_5678;
        half();
        e = 9'b1000_1_1_0_0_0;
        checks++; if (obs !== e) begin failures++; $display("FAIL rd_ready obs=%b exp=%b", obs, e); end
        checks++; if (up_if.PRDATA !== 32'h1234_5678) begin failures++; $display("FAIL rd_data got=%h exp=12345678", up_if.PRDATA); end
        tick();
        drive_up(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        drive_dn(4'b0000, 4'b0000);
        half();
        e = 9'b0000_0_0_0_0_0;
        checks++; if (obs !== e) begin failures++; $display("FAIL rd_after obs=%b exp=%b", obs, e); end
        checks++; if (up_if.PRDATA !== 32'h0) begin failures++; $display("FAIL rd_after_data got=%h exp=0", up_if.PRDATA); end
        tick();
    endtask

    task automatic test_unmapped();
        logic [8:0] e;
        drive_up(1'b1, 1'b0, 32'h5000_0000, 1'b0, 32'h0);
        drive_dn(4'b1111, 4'b1111);
        half();
        e = 9'b0000_0_0_0_0_0;
        checks++; if (obs !== e) begin failures++; $display("FAIL unm_setup obs=%b exp=%b", obs, e); end
        tick();
        drive_up(1'b1, 1'b1, 32'h5000_0000, 1'b0, 32'h0);
        drive_dn(4'b0000, 4'b0000);
        half();
        e = 9'b0000_1_1_1_0_0;
        checks++; if (obs !== e) begin failures++; $display("FAIL unm_access obs=%b exp=%b", obs, e); end
        checks++; if (up_if.PRDATA !== 32'h0) begin failures++; $display("FAIL unm_data got=%h exp=0", up_if.PRDATA); end
        tick();
        drive_up(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        half();
        e = 9'b0000_0_0_0_1_0;
        checks++; if (obs !== e) begin failures++; $display("FAIL unm_pulse obs=%b exp=%b", obs, e); end
        tick();
        half();
        e = 9'b0000_0_0_0_0_0;
        checks++; if (obs !== e) begin failures++; $display("FAIL unm_pulse_end obs=%b exp=%b", obs, e); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [8:0]  e;
        logic [31:0] v;
        drive_up(1'b1, 1'b0, 32'h4000_0010, 1'b1, 32'hA5A5_0001);
        drive_dn(4'b0001, 4'b0000);
        half();
        e = 9'b0001_0_0_0_0_0;
        checks++; if (obs !== e) begin failures++; $display("FAIL b2b_wr_setup obs=%b exp=%b", obs, e); end
        tick();
        drive_up(1'b1, 1'b1, 32'h4000_0010, 1'b1, 32'hA5A5_0001);
        half();
        e = 9'b0001_1_1_0_0_0;
        checks++; if (obs !== e) begin failures++; $display("FAIL b2b_wr_access obs=%b exp=%b", obs, e); end
        tick();
        drive_up(1'b1, 1'b0, 32'h4000_2008, 1'b0, 32'h0);
        drive_dn(4'b0100, 4'b0100);
        half();
        e = 9'b0100_0_0_0_0_0;
        checks++; if (obs !== e) begin failures++; $display("FAIL b2b_rd_setup obs=%b exp=%b", obs, e); end
        tick();
        v = $urandom;
        drive_up(1'b1, 1'b1, 32'h4000_2008, 1'b0, 32'h0);
        drive_dn(4'b0100, 4'b0100);
        PRDATA_dn[2] = v;
        half();
        e = 9'b0100_1_1_1_0_0;
        checks++; if (obs !== e) begin failures++; $display("FAIL b2b_rd_access obs=%b exp=%b", obs, e); end
        checks++; if (up_if.PRDATA !== v) begin failures++; $display("FAIL b2b_rd_data got=%h exp=%h", up_if.PRDATA, v); end
        tick();
        drive_up(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        drive_dn(4'b0000, 4'b0000);
        half();
        e = 9'b0000_0_0_0_0_0;
        checks++; if (obs !== e) begin failures++; $display("FAIL b2b_after obs=%b exp=%b", obs, e); end
        tick();
    endtask

    task automatic test_prot_err();
        logic [8:0] e;
        // Access phase with no setup phase
        drive_up(1'b1, 1'b1, 32'h4000_1000, 1'b0, 32'h0);
        drive_dn(4'b1111, 4'b0000);
        half();
        e = 9'b0000_0_0_0_0_0;
        checks++; if (obs !== e) begin failures++; $display("FAIL prot_noset obs=%b exp=%b", obs, e); end
        tick();
        // A setup in the very next cycle must be accepted (still IDLE)
        drive_up(1'b1, 1'b0, 32'h4000_2000, 1'b0, 32'h0);
        drive_dn(4'b0000, 4'b0000);
        half();
        e = 9'b0100_0_0_0_0_1;
        checks++; if (obs !== e) begin failures++; $display("FAIL prot_noset_pulse obs=%b exp=%b", obs, e); end
        tick();
        drive_up(1'b1, 1'b1, 32'h4000_2000, 1'b0, 32'h0);
        drive_dn(4'b1011, 4'b0000);
        half();
        e = 9'b0100_1_0_0_0_0;
        checks++; if (obs !== e) begin failures++; $display("FAIL prot_access obs=%b exp=%b", obs, e); end
        tick();
        // Master drops PSEL before the slave answered
        drive_up(1'b0, 1'b0, 32'h4000_2000, 1'b0, 32'h0);
        drive_dn(4'b0100, 4'b0000);
        half();
        e = 9'b0000_0_0_0_0_0;
        checks++; if (obs !== e) begin failures++; $display("FAIL prot_drop obs=%b exp=%b", obs, e); end
        tick();
        drive_up(1'b1, 1'b0, 32'h4000_1000, 1'b0, 32'h0);
        drive_dn(4'b0010, 4'b0000);
        half();
        e = 9'b0010_0_0_0_0_1;
        checks++; if (obs !== e) begin failures++; $display("FAIL prot_drop_pulse obs=%b exp=%b", obs, e); end
        tick();
        drive_up(1'b1, 1'b1, 32'h4000_1000, 1'b0, 32'h0);
        half();
        e = 9'b0010_1_1_0_0_0;
        checks++; if (obs !== e) begin failures++; $display("FAIL prot_recover obs=%b exp=%b", obs, e); end
        tick();
        drive_up(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        drive_dn(4'b0000, 4'b0000);
        tick();
    endtask

    task automatic test_reset_mid();
        logic [8:0] e;
        drive_up(1'b1, 1'b0, 32'h4000_1000, 1'b1, 32'h0);
        drive_dn(4'b0000, 4'b0000);
        tick();
        drive_up(1'b1, 1'b1, 32'h4000_1000, 1'b1, 32'h0);
        half();
        e = 9'b0010_1_0_0_0_0;
        checks++; if (obs !== e) begin failures++; $display("FAIL rstmid_access obs=%b exp=%b", obs, e); end
        #2;
        PRESETn = 1'b0;
        #1;
        e = 9'b0000_0_0_0_0_0;
        checks++; if (obs !== e) begin failures++; $display("FAIL rstmid_reset obs=%b exp=%b", obs, e); end
        tick();
        drive_up(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        PRESETn = 1'b1;
        half();
        checks++; if (obs !== e) begin failures++; $display("FAIL rstmid_release obs=%b exp=%b", obs, e); end
        tick();
        drive_up(1'b1, 1'b0, 32'h4000_3000, 1'b0, 32'h0);
        drive_dn(4'b1000, 4'b0000);
        half();
        e = 9'b1000_0_0_0_0_0;
        checks++; if (obs !== e) begin failures++; $display("FAIL rstmid_setup obs=%b exp=%b", obs, e); end
        tick();
        drive_up(1'b1, 1'b1, 32'h4000_3000, 1'b0, 32'h0);
        half();
        e = 9'b1000_1_1_0_0_0;
        checks++; if (obs !== e) begin failures++; $display("FAIL rstmid_done obs=%b exp=%b", obs, e); end
        tick();
        drive_up(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        drive_dn(4'b0000, 4'b0000);
        tick();
    endtask

    // Random transfer stream. Expected routing comes from the address map:
    // in-window addresses select slave (addr>>12)%4, all else is unmapped.
    task automatic test_random();
        logic [8:0]  e;
        logic [31:0] addr, wd, rd;
        logic        wr, hit, err, pend_unm;
        logic [3:0]  exp_sel, rdy, errv;
        int          idx, waits, gap;
        pend_unm = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(3) != 0) addr = {BASE[31:14], 14'($urandom)};
            else                        addr = $urandom;
            wr      = 1'($urandom);
            wd      = $urandom;
            hit     = ((addr >> 14) == (BASE >> 14));
            idx     = int'((addr >> 12) & 32'h3);
            exp_sel = hit ? (4'b0001 << idx) : 4'b0000;
            waits   = $urandom_range(0, 3);
            err     = 1'($urandom);
            gap     = $urandom_range(0, 1);

            drive_up(1'b1, 1'b0, addr, wr, wd);
            drive_dn(4'($urandom), 4'($urandom));
            half();
            e = {exp_sel, 1'b0, 1'b0, 1'b0, pend_unm, 1'b0};
            checks++; if (obs !== e) begin failures++; $display("FAIL rnd%0d_setup addr=%h obs=%b exp=%b", t, addr, obs, e); end
            checks++; if (PADDR_dn !== addr) begin failures++; $display("FAIL rnd%0d_paddr got=%h exp=%h", t, PADDR_dn, addr); end
            tick();
            pend_unm = 1'b0;

            if (hit) begin
                for (int k = 0; k <= waits; k++) begin
                    rdy       = 4'($urandom);
                    errv      = 4'($urandom);
                    rdy[idx]  = (k == waits);
                    errv[idx] = (k == waits) ? err : 1'b0;
                    rd        = $urandom;
                    drive_up(1'b1, 1'b1, $urandom, wr, wd);
                    drive_dn(rdy, errv);
                    PRDATA_dn[idx] = rd;
                    half();
                    e = {exp_sel, 1'b1, (k == waits), (k == waits) & err, 1'b0, 1'b0};
                    checks++; if (obs !== e) begin failures++; $display("FAIL rnd%0d_acc%0d obs=%b exp=%b", t, k, obs, e); end
                    if (k == waits && !wr) begin
                        checks++; if (up_if.PRDATA !== rd) begin failures++; $display("FAIL rnd%0d_rdata got=%h exp=%h", t, up_if.PRDATA, rd); end
                    end
                    tick();
                end
            end else begin
                drive_up(1'b1, 1'b1, addr, wr, wd);
                drive_dn(4'($urandom), 4'($urandom));
                half();
                e = {4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
                checks++; if (obs !== e) begin failures++; $display("FAIL rnd%0d_unm obs=%b exp=%b", t, obs, e); end
                checks++; if (up_if.PRDATA !== 32'h0) begin failures++; $display("FAIL rnd%0d_unm_data got=%h exp=0", t, up_if.PRDATA); end
                tick();
                pend_unm = 1'b1;
            end

            if (gap != 0) begin
                drive_up(1'b0, 1'b0, $urandom, 1'b0, 32'h0);
                drive_dn(4'($urandom), 4'($urandom));
                half();
                e = {4'b0000, 1'b0, 1'b0, 1'b0, pend_unm, 1'b0};
                checks++; if (obs !== e) begin failures++; $display("FAIL rnd%0d_gap obs=%b exp=%b", t, obs, e); end
                tick();
                pend_unm = 1'b0;
            end
        end
        drive_up(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        drive_dn(4'b0000, 4'b0000);
        half();
        e = {4'b0000, 1'b0, 1'b0, 1'b0, pend_unm, 1'b0};
        checks++; if (obs !== e) begin failures++; $display("FAIL rnd_tail obs=%b exp=%b", obs, e); end
        tick();
    endtask

`ifdef APB_DEC_TIMEOUT_EN
    task automatic test_timeout();
        logic [8:0] e;
        drive_up(1'b1, 1'b0, 32'h4000_2000, 1'b0, 32'h0);
        drive_dn(4'b0000, 4'b0000);
        half();
        e = 9'b0100_0_0_0_0_0;
        checks++; if (obs !== e) begin failures++; $display("FAIL to_setup obs=%b exp=%b", obs, e); end
        tick();
        for (int c = 1; c <= 16; c++) begin
            drive_up(1'b1, 1'b1, 32'h4000_2000, 1'b0, 32'h0);
            drive_dn(4'b1011, 4'b0000);
            half();
            e = (c < 16) ? 9'b0100_1_0_0_0_0 : 9'b0000_0_1_1_0_0;
            checks++; if (obs !== e) begin failures++; $display("FAIL to_cycle%0d obs=%b exp=%b", c, obs, e); end
            if (c == 16) begin
                checks++; if (up_if.PRDATA !== 32'h0) begin failures++; $display("FAIL to_data got=%h exp=0", up_if.PRDATA); end
            end
            tick();
        end
        drive_up(1'b1, 1'b0, 32'h4000_0000, 1'b1, 32'h0);
        drive_dn(4'b0001, 4'b0000);
        half();
        e = 9'b0001_0_0_0_0_0;
        checks++; if (obs !== e) begin failures++; $display("FAIL to_next_setup obs=%b exp=%b", obs, e); end
        checks++; if (timeout_pulse !== 1'b1) begin failures++; $display("FAIL to_pulse got=%b exp=1", timeout_pulse); end
        tick();
        drive_up(1'b1, 1'b1, 32'h4000_0000, 1'b1, 32'h0);
        half();
        e = 9'b0001_1_1_0_0_0;
        checks++; if (obs !== e) begin failures++; $display("FAIL to_next_done obs=%b exp=%b", obs, e); end
        checks++; if (timeout_pulse !== 1'b0) begin failures++; $display("FAIL to_pulse_end got=%b exp=0", timeout_pulse); end
        tick();
        drive_up(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        drive_dn(4'b0000, 4'b0000);
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_write_single();
        test_read_wait();
        test_unmapped();
        test_back_to_back();
        test_prot_err();
        test_reset_mid();
        test_random();
`ifdef APB_DEC_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
